serial_add_seq: RTL and testbench

//   Sequencer that time-shares one external gate-level 1-bit full adder (a, b, ci -> sum, co)
//   to add two WIDTH-bit operands bit-serially, LSB first. Drives the adder inputs from

---
 rtl/serial_add_seq_if.sv | 30 +++
 rtl/serial_add_seq.sv | 169 ++++++++++++++++
 tb/tb_serial_add_seq.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_seq_if
// Brief    : Command/result bundle between a requester and serial_add_seq.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_add_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, abort, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, abort, a, b, cin,
        output busy, done, sum, cout
    );
endinterface
`default_nettype wire

// File: rtl/serial_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_seq
// Brief    : Bit-serial adder sequencer time-sharing one external full adder.
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_seq #(
    parameter int WIDTH      = 8,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_add_seq_if.slave  cmd,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_ci,
    input  logic             fa_sum,
    input  logic             fa_co
);

    localparam int C_IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int C_CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [C_IDX_W-1:0] C_IDX_LAST = C_IDX_W'(WIDTH - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_INIT = C_CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [C_IDX_W-1:0] r_idx, w_idx_nxt;
    logic [C_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic               r_carry, w_carry_nxt;
    logic [WIDTH-1:0]   r_a, w_a_nxt;
    logic [WIDTH-1:0]   r_b, w_b_nxt;
    logic [WIDTH-1:0]   r_part, w_part_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic [WIDTH-1:0]   r_sum, w_sum_nxt;
    logic               r_cout, w_cout_nxt;
    logic               r_fa_a, w_fa_a_nxt;
    logic               r_fa_b, w_fa_b_nxt;
    logic               r_fa_ci, w_fa_ci_nxt;
    logic [C_IDX_W-1:0] w_idx_inc;

    assign w_idx_inc = r_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_part  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_fa_a  <= 1'b0;
            r_fa_b  <= 1'b0;
            r_fa_ci <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_carry <= w_carry_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_part  <= w_part_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_sum   <= w_sum_nxt;
            r_cout  <= w_cout_nxt;
            r_fa_a  <= w_fa_a_nxt;
            r_fa_b  <= w_fa_b_nxt;
            r_fa_ci <= w_fa_ci_nxt;
        end
    end

    // Adder inputs are loaded on the edge that enters each bit, so they are
    // already stable for the whole settle window of that bit.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_carry_nxt = r_carry;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_part_nxt  = r_part;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_sum_nxt   = r_sum;
        w_cout_nxt  = r_cout;
        w_fa_a_nxt  = r_fa_a;
        w_fa_b_nxt  = r_fa_b;
        w_fa_ci_nxt = r_fa_ci;

        case (r_state)
            S_IDLE: begin
                if (cmd.start && !cmd.abort) begin
                    w_state_nxt = S_SETTLE;
                    w_a_nxt     = cmd.a;
                    w_b_nxt     = cmd.b;
                    w_carry_nxt = cmd.cin;
                    w_part_nxt  = '0;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = C_CNT_INIT;
                    w_busy_nxt  = 1'b1;
                    w_fa_a_nxt  = cmd.a[0];
                    w_fa_b_nxt  = cmd.b[0];
                    w_fa_ci_nxt = cmd.cin;
                end
            end

            S_SETTLE: begin
                if (cmd.abort) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_fa_a_nxt  = 1'b0;
                    w_fa_b_nxt  = 1'b0;
                    w_fa_ci_nxt = 1'b0;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_part_nxt[r_idx] = fa_sum;
                    w_carry_nxt       = fa_co;
                    if (r_idx == C_IDX_LAST) begin
                        w_state_nxt = S_DONE;
                        w_busy_nxt  = 1'b0;
                        w_fa_a_nxt  = 1'b0;
                        w_fa_b_nxt  = 1'b0;
                        w_fa_ci_nxt = 1'b0;
                    end else begin
                        w_idx_nxt   = w_idx_inc;
                        w_cnt_nxt   = C_CNT_INIT;
                        w_fa_a_nxt  = r_a[w_idx_inc];
                        w_fa_b_nxt  = r_b[w_idx_inc];
                        w_fa_ci_nxt = fa_co;
                    end
                end
            end

            S_DONE: begin
                w_sum_nxt   = r_part;
                w_cout_nxt  = r_carry;
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign cmd.busy = r_busy;
    assign cmd.done = r_done;
    assign cmd.sum  = r_sum;
    assign cmd.cout = r_cout;
    assign fa_a     = r_fa_a;
    assign fa_b     = r_fa_b;
    assign fa_ci    = r_fa_ci;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_seq
// Brief    : Directed scoreboard bench for serial_add_seq with a delayed adder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_seq;
    localparam int WIDTH      = 4;
    localparam int SETTLE_CYC = 2;
    localparam int LAT        = WIDTH * SETTLE_CYC + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_add_seq_if #(.WIDTH(WIDTH)) cmd ();

    logic fa_a, fa_b, fa_ci;
    logic fa_sum = 1'b0;
    logic fa_co  = 1'b0;
    logic g_p, g_g;

    serial_add_seq #(.WIDTH(WIDTH), .SETTLE_CYC(SETTLE_CYC)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cmd    (cmd),
        .fa_a   (fa_a),
        .fa_b   (fa_b),
        .fa_ci  (fa_ci),
        .fa_sum (fa_sum),
        .fa_co  (fa_co)
    );

    // Gate-level full adder with a few ns of propagation per stage
    always @(fa_a or fa_b or fa_ci) begin
        #1 g_p = fa_a ^ fa_b;
           g_g = fa_a & fa_b;
        #1 fa_sum = g_p ^ fa_ci;
        #1 fa_co  = g_g | (g_p & fa_ci);
    end

    int n_vec  = 0;
    int n_err  = 0;
    int n_done = 0;
    int lat;
    int busy_cnt;
    int base;
    logic [WIDTH:0] sb_q[$];
    logic           fa_ci_log[0:15];

    always @(negedge clk) if (cmd.done === 1'b1) n_done++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                          input logic ic, input bit push);
        cmd.a     = ia;
        cmd.b     = ib;
        cmd.cin   = ic;
        cmd.start = 1'b1;
        if (push) sb_q.push_back({1'b0, ia} + {1'b0, ib} + {{WIDTH{1'b0}}, ic});
        step();
        cmd.start = 1'b0;
    endtask

    // Entered in the cycle right after the accepting edge (cycle 0)
    task automatic wait_done(input string tag, input int exp_lat, input int start_lat);
        logic [WIDTH:0] exp;
        lat      = start_lat;
        busy_cnt = 0;
        for (int i = 0; i < 16; i++) fa_ci_log[i] = 1'b0;
        while (cmd.done !== 1'b1 && lat < 40) begin
            if (cmd.busy === 1'b1) busy_cnt++;
            if (lat < 16) fa_ci_log[lat] = fa_ci;
            step();
            lat++;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " queued"}, sb_q.size(), 1);
        if (sb_q.size() > 0) exp = sb_q.pop_front();
        else exp = 'x;
        chk({tag, " result"}, {cmd.cout, cmd.sum}, exp);
    endtask

    initial begin
        cmd.start = 1'b0;
        cmd.abort = 1'b0;
        cmd.a     = '0;
        cmd.b     = '0;
        cmd.cin   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", cmd.busy, 0);
        chk("rst done", cmd.done, 0);
        chk("rst sum", {cmd.cout, cmd.sum}, 0);
        chk("rst fa", {fa_a, fa_b, fa_ci}, 0);
        @(negedge clk) rst_n = 1'b1;
        step();

        // 1: 3 + 5
        launch(4'h3, 4'h5, 1'b0, 1'b1);
        wait_done("t1", LAT, 0);
        chk("t1 busy cycles", busy_cnt, WIDTH * SETTLE_CYC);
        step();
        chk("t1 done pulse", cmd.done, 0);
        chk("t1 fa idle", {fa_a, fa_b, fa_ci}, 0);

        // 2: F + 1, carry rippled through the flop
        launch(4'hF, 4'h1, 1'b0, 1'b1);
        wait_done("t2", LAT, 0);
        chk("t2 fa_ci bit0", fa_ci_log[0], 0);
        chk("t2 fa_ci bit1", fa_ci_log[2], 1);
        chk("t2 fa_ci bit2", fa_ci_log[4], 1);
        chk("t2 fa_ci bit3", fa_ci_log[6], 1);
        chk("t2 fa_ci done", fa_ci_log[8], 0);

        // 3: F + F + 1 then 0 + 0 back-to-back
        launch(4'hF, 4'hF, 1'b1, 1'b1);
        wait_done("t3a", LAT, 0);
        launch(4'h0, 4'h0, 1'b0, 1'b1);
        chk("t3b prev done cleared", cmd.done, 0);
        wait_done("t3b", LAT, 0);
        step();

        // 4: start while busy is ignored
        base = n_done;
        launch(4'h6, 4'h7, 1'b0, 1'b1);
        repeat (3) step();
        cmd.a     = 4'h1;
        cmd.b     = 4'h1;
        cmd.start = 1'b1;
        step();
        cmd.start = 1'b0;
        wait_done("t4", LAT, 4);
        repeat (2) step();
        chk("t4 single done", n_done - base, 1);
        chk("t4 queue empty", sb_q.size(), 0);

        // 5: abort mid-op keeps the previous result
        launch(4'h3, 4'h5, 1'b0, 1'b1);
        wait_done("t5 pre", LAT, 0);
        step();
        base = n_done;
        launch(4'h7, 4'h7, 1'b0, 1'b0);
        repeat (2) step();
        cmd.abort = 1'b1;
        step();
        cmd.abort = 1'b0;
        chk("t5 busy after abort", cmd.busy, 0);
        repeat (15) step();
        chk("t5 no done", n_done - base, 0);
        chk("t5 sum held", {cmd.cout, cmd.sum}, 5'h08);

        // abort in IDLE overrides start
        cmd.start = 1'b1;
        cmd.abort = 1'b1;
        step();
        cmd.start = 1'b0;
        cmd.abort = 1'b0;
        chk("t5 abort beats start", cmd.busy, 0);
        repeat (12) step();
        chk("t5 start dropped", n_done - base, 0);

        // 6: asynchronous reset mid-op
        launch(4'hF, 4'hF, 1'b0, 1'b0);
        repeat (2) step();
        #2 rst_n = 1'b0;
        #1;
        chk("t6 rst busy", cmd.busy, 0);
        chk("t6 rst done", cmd.done, 0);
        chk("t6 rst sum", {cmd.cout, cmd.sum}, 0);
        chk("t6 rst fa", {fa_a, fa_b, fa_ci}, 0);
        @(negedge clk) rst_n = 1'b1;
        step();
        launch(4'h2, 4'h2, 1'b0, 1'b1);
        wait_done("t6 post", LAT, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
